// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types and helpers for the JK bank arbiter.
// The op encoding is the raw {J,K} pair applied to a cell.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'd0,
    JK_CLR  = 2'd1,
    JK_SET  = 2'd2,
    JK_TGL  = 2'd3
  } jk_op_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Request/grant bus between control agents and the JK bank arbiter.
// Requester i owns slice i of req_valid/req_op/req_addr.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 3,
  parameter int AW    = $clog2(WIDTH),
  parameter int IDW   = $clog2(NREQ)
);

  logic                 count_en;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [AW*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [WIDTH-1:0]     q;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 addr_err;
  logic                 wrap;

  // Control agents drive requests and observe the bank.
  modport master (
    output count_en, req_valid, req_op, req_addr,
    input  req_ready, q, grant_valid, grant_id, addr_err, wrap
  );

  // The arbiter consumes requests and publishes the bank state.
  modport slave (
    input  count_en, req_valid, req_op, req_addr,
    output req_ready, q, grant_valid, grant_id, addr_err, wrap
  );

endinterface

// File: rtl/jk_bank_arbiter_jk_cell.sv
// One JK flip-flop of the bank, synchronous reset to 0.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK behaviour: hold / clear / set / toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (jk_op_t'({j, k}))
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing write access to a bank of JK cells.
// Each transfer applies one {J,K} op to one addressed cell; count mode
// instead steers every cell as a stage of a synchronous up-counter.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 3,
  parameter int AW    = $clog2(WIDTH),
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  jk_bank_arbiter_if.slave   bus
);

  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   rr_ptr_next;
  logic [NREQ-1:0]  grant_oh;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_op;
  logic [AW-1:0]    win_addr;
  logic             xfer;
  logic             addr_bad;
  logic [WIDTH-1:0] q_vec;

  logic             grant_valid_reg;
  logic [IDW-1:0]   grant_id_reg;
  logic             addr_err_reg;
  logic             wrap_reg;

  // Round-robin search starting at the pointer; no grants in reset or count mode.
  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    win_found = 1'b0;
    win_id    = '0;
    if (!rst && !bus.count_en) begin
      for (int s = 0; s < NREQ; s++) begin
        idx = int'(rr_ptr_reg) + s;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!win_found && bus.req_valid[idx]) begin
          win_found     = 1'b1;
          win_id        = IDW'(idx);
          grant_oh[idx] = 1'b1;
        end
      end
    end
  end

  // Route the winning requester's op and address toward the bank.
  always_comb begin
    win_op   = bus.req_op[2*int'(win_id) +: 2];
    win_addr = bus.req_addr[AW*int'(win_id) +: AW];
    xfer     = |(bus.req_valid & grant_oh);
    // Only reachable when WIDTH is not a power of two: consumed but ignored.
    addr_bad = xfer && (int'(win_addr) >= WIDTH);
  end

  // Pointer moves past the winner only when a transfer actually happens.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer) rr_ptr_next = IDW'(rr_next(int'(win_id), NREQ));
  end

  assign bus.req_ready = grant_oh;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic carry_in;
      logic j_bit;
      logic k_bit;

      // Counter carry into this stage: all lower cells are ones.
      if (gi == 0) begin : g_lsb
        assign carry_in = 1'b1;
      end else begin : g_upper
        assign carry_in = &q_vec[gi-1:0];
      end

      // Count mode toggles on carry; otherwise only the addressed cell sees the op.
      always_comb begin
        j_bit = 1'b0;
        k_bit = 1'b0;
        if (bus.count_en) begin
          j_bit = carry_in;
          k_bit = carry_in;
        end else if (xfer && (win_addr == AW'(gi))) begin
          j_bit = win_op[1];
          k_bit = win_op[0];
        end
      end

      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j_bit),
        .k   (k_bit),
        .q   (q_vec[gi])
      );
    end
  endgenerate

  // Status pulses and the arbitration pointer, all reported one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg      <= '0;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= '0;
      addr_err_reg    <= 1'b0;
      wrap_reg        <= 1'b0;
    end else begin
      rr_ptr_reg      <= rr_ptr_next;
      grant_valid_reg <= xfer;
      if (xfer) grant_id_reg <= win_id;
      addr_err_reg    <= addr_bad;
      wrap_reg        <= bus.count_en & (&q_vec);
    end
  end

  assign bus.q           = q_vec;
  assign bus.grant_valid = grant_valid_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.addr_err    = addr_err_reg;
  assign bus.wrap        = wrap_reg;

endmodule
